// File: rtl/t5_hart.sv
// t5 barrel-core hart scheduler: per-hart PC/state array with round-robin issue to fetch.
// Define T5_HART_PRIO_EN to replace round-robin with fixed lowest-hart-first priority.
module t5_hart #(
  parameter int              HLEN  = 2,
  parameter int              XLEN  = 32,
  parameter logic [XLEN-1:0] RSTPC = '0
) (
  input  logic                   sclk_i,
  input  logic                   srst_i,
  input  logic                   sena_i,
  input  logic [(2**HLEN)-1:0]   hena_i,
  input  logic                   xupd_i,
  input  logic [HLEN-1:0]        xhart_i,
  input  logic [XLEN-1:0]        xpc_i,
  input  logic                   xbra_i,
  input  logic [XLEN-1:0]        xbpc_i,
  input  logic                   xmem_i,
  input  logic                   dwb_ack_i,
  output logic                   fvld_o,
  output logic [HLEN-1:0]        fhart_o,
  output logic [XLEN-1:0]        fpc_o,
  output logic [2*(2**HLEN)-1:0] hsta_o
);

  localparam int NH = 2**HLEN;

  typedef enum logic [1:0] {
    ST_OFF  = 2'd0,
    ST_RDY  = 2'd1,
    ST_FLY  = 2'd2,
    ST_WAIT = 2'd3
  } hstate_e;

  hstate_e           state_q [NH];
  hstate_e           state_d [NH];
  logic [XLEN-1:0]   pc_q    [NH];
  logic [XLEN-1:0]   pc_d    [NH];
  logic [HLEN-1:0]   mhart_q;
  logic [HLEN-1:0]   mhart_d;
  logic              fvld_q;
  logic [HLEN-1:0]   fhart_q;
  logic [XLEN-1:0]   fpc_q;
`ifndef T5_HART_PRIO_EN
  logic [HLEN-1:0]   ptr_q;
`endif

  logic [NH-1:0]     elig;
  logic              sel_vld;
  logic [HLEN-1:0]   sel_hart;

  // A RDY hart whose enable has dropped is leaving this cycle, so it never competes.
  always_comb begin
    elig = '0;
    for (int h = 0; h < NH; h++) begin
      elig[h] = (state_q[h] == ST_RDY) && hena_i[h];
    end
  end

  // Scan in reverse so the last hit written is the first hart in priority order.
  always_comb begin
    sel_vld  = 1'b0;
    sel_hart = '0;
`ifdef T5_HART_PRIO_EN
    for (int i = NH - 1; i >= 0; i--) begin
      if (elig[i]) begin
        sel_vld  = 1'b1;
        sel_hart = HLEN'(i);
      end
    end
`else
    for (int i = NH; i >= 1; i--) begin
      if (elig[ptr_q + HLEN'(i)]) begin
        sel_vld  = 1'b1;
        sel_hart = ptr_q + HLEN'(i);
      end
    end
`endif
  end

  always_comb begin
    mhart_d = mhart_q;
    for (int h = 0; h < NH; h++) begin
      state_d[h] = state_q[h];
      pc_d[h]    = pc_q[h];
    end
    if (sena_i) begin
      for (int h = 0; h < NH; h++) begin
        case (state_q[h])
          ST_OFF: begin
            if (hena_i[h]) begin
              state_d[h] = ST_RDY;
              pc_d[h]    = RSTPC;
            end
          end
          ST_RDY: begin
            if (sel_vld && (sel_hart == HLEN'(h))) begin
              state_d[h] = ST_FLY;
            end else if (!hena_i[h]) begin
              state_d[h] = ST_OFF;
            end
          end
          ST_FLY: begin
            if (xupd_i && (xhart_i == HLEN'(h))) begin
              pc_d[h] = xbra_i ? xbpc_i : (xpc_i + XLEN'(4));
              if (xmem_i) begin
                state_d[h] = ST_WAIT;
                mhart_d    = HLEN'(h);
              end else begin
                state_d[h] = ST_RDY;
              end
            end
          end
          ST_WAIT: begin
            if (dwb_ack_i && (mhart_q == HLEN'(h))) begin
              state_d[h] = ST_RDY;
            end
          end
          default: state_d[h] = ST_OFF;
        endcase
      end
    end
  end

  always_ff @(posedge sclk_i or posedge srst_i) begin
    if (srst_i) begin
      for (int h = 0; h < NH; h++) begin
        state_q[h] <= ST_OFF;
        pc_q[h]    <= RSTPC;
      end
      mhart_q <= '0;
      fvld_q  <= 1'b0;
      fhart_q <= '0;
      fpc_q   <= '0;
`ifndef T5_HART_PRIO_EN
      ptr_q   <= HLEN'(NH - 1);
`endif
    end else begin
      for (int h = 0; h < NH; h++) begin
        state_q[h] <= state_d[h];
        pc_q[h]    <= pc_d[h];
      end
      mhart_q <= mhart_d;
      if (sena_i) begin
        fvld_q <= sel_vld;
        if (sel_vld) begin
          fhart_q <= sel_hart;
          fpc_q   <= pc_q[sel_hart];
`ifndef T5_HART_PRIO_EN
          ptr_q   <= sel_hart;
`endif
        end
      end
    end
  end

  always_comb begin
    hsta_o = '0;
    for (int h = 0; h < NH; h++) begin
      hsta_o[2*h +: 2] = state_q[h];
    end
  end

  assign fvld_o  = fvld_q;
  assign fhart_o = fhart_q;
  assign fpc_o   = fpc_q;

endmodule
